ob_tbl_sched: RTL and testbench

OB_TBL_SCHED -- requirements
Module: ob_tbl_sched

---
 rtl/ob_tbl_sched.sv | 160 ++++++++++++++++
 tb/tb_ob_tbl_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_tbl_sched.sv
// Order-table request scheduler: arbitrates pop/cancel/push/insert requests
// onto a single table port, tracks occupancy, returns cancel results and
// sequences a head-pop flush.

package ob_pkg;
  typedef logic [31:0] table_t;
  typedef logic [7:0]  uid_t;
endpackage

module ob_tbl_sched #(
  parameter int N       = 16,
  parameter int AGE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pop_vld,
  output logic                   pop_rdy,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  ob_pkg::table_t         push_tbl,
  input  logic                   ins_vld,
  output logic                   ins_rdy,
  input  ob_pkg::table_t         ins_tbl,
  input  logic                   cnl_vld,
  output logic                   cnl_rdy,
  input  ob_pkg::uid_t           cnl_uid,
  output logic                   cnl_rsp_vld,
  input  logic                   cnl_rsp_rdy,
  output logic                   cnl_rsp_hit,
  output ob_pkg::table_t         cnl_rsp_tbl,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   tbl_head_pop,
  output logic                   tbl_head_push,
  output logic                   tbl_insert,
  output logic                   tbl_cancel,
  output ob_pkg::table_t         tbl_push_tbl,
  output ob_pkg::table_t         tbl_insert_tbl,
  output ob_pkg::uid_t           tbl_cancel_uid,
  input  logic                   tbl_cancel_hit,
  input  ob_pkg::table_t         tbl_cancel_hit_tbl,
  output logic [$clog2(N+1)-1:0] occ_r
);

  localparam int OW = $clog2(N + 1);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(N);
  localparam logic [AW-1:0] AGE_SAT  = AW'(AGE_MAX);

  typedef enum logic [1:0] {RUN, CNL_RSP, FLUSH} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] age;

  logic arb_on, pop_el, cnl_el, add_el, aged;
  logic pop_take, cnl_take, push_take, aged_ins;
  logic pop_ok, cnl_ok, push_ok, ins_ok;
  logic pop_g, cnl_g, push_g, ins_g;
  logic flush_pop;

  // Eligibility and fixed-priority arbitration; each ready is derived from
  // the competing requests only, never from the requester's own valid.
  always_comb begin
    arb_on    = (state == CNL_RSP) || ((state == RUN) && !flush);
    pop_el    = arb_on && (occ_r != '0);
    cnl_el    = arb_on && (state == RUN);
    add_el    = arb_on && (occ_r < OCC_FULL);
    aged      = (age == AGE_SAT);
    pop_take  = pop_vld && pop_el;
    cnl_take  = cnl_vld && cnl_el;
    push_take = push_vld && add_el;
    aged_ins  = aged && ins_vld && add_el;
    pop_ok    = pop_el;
    cnl_ok    = cnl_el && !pop_take;
    push_ok   = add_el && !pop_take && !cnl_take && !aged_ins;
    ins_ok    = add_el && !pop_take && !cnl_take && (aged || !push_take);
    pop_g     = pop_vld && pop_ok;
    cnl_g     = cnl_vld && cnl_ok;
    push_g    = push_vld && push_ok;
    ins_g     = ins_vld && ins_ok;
    flush_pop = (state == FLUSH) && (occ_r != '0);
  end

  // Handshake outputs are forced low while reset is held; the internal
  // grants feeding the registers are left ungated since reset dominates there.
  assign pop_rdy        = rst_n & pop_ok;
  assign cnl_rdy        = rst_n & cnl_ok;
  assign push_rdy       = rst_n & push_ok;
  assign ins_rdy        = rst_n & ins_ok;
  assign tbl_head_pop   = (rst_n & pop_g) | flush_pop;
  assign tbl_cancel     = rst_n & cnl_g;
  assign tbl_head_push  = rst_n & push_g;
  assign tbl_insert     = rst_n & ins_g;
  assign tbl_push_tbl   = push_tbl;
  assign tbl_insert_tbl = ins_tbl;
  assign tbl_cancel_uid = cnl_uid;
  assign flush_done     = (state == FLUSH) && (occ_r == '0);
  assign cnl_rsp_vld    = (state == CNL_RSP);

  // Next-state selection for the run / cancel-response / flush sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (flush)      state_nxt = FLUSH;
        else if (cnl_g) state_nxt = CNL_RSP;
      end
      CNL_RSP: begin
        if (cnl_rsp_rdy) state_nxt = flush ? FLUSH : RUN;
      end
      FLUSH: begin
        if (occ_r == '0) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Occupancy: removals (pop, flush pop, cancel hit) and additions are
  // mutually exclusive because only one table operation happens per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occ_r <= '0;
    else if (pop_g || flush_pop || (cnl_g && tbl_cancel_hit))
      occ_r <= occ_r - OW'(1);
    else if (push_g || ins_g)
      occ_r <= occ_r + OW'(1);
  end

  // Insert starvation counter, saturating at AGE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      age <= '0;
    else if (flush_done || ins_g || !ins_vld)
      age <= '0;
    else if (!aged)
      age <= age + AW'(1);
  end

  // Cancel response capture; held until accepted, zeroed on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnl_rsp_hit <= 1'b0;
      cnl_rsp_tbl <= '0;
    end else if (cnl_g) begin
      cnl_rsp_hit <= tbl_cancel_hit;
      cnl_rsp_tbl <= tbl_cancel_hit ? tbl_cancel_hit_tbl : '0;
    end else if ((state == CNL_RSP) && cnl_rsp_rdy) begin
      cnl_rsp_hit <= 1'b0;
      cnl_rsp_tbl <= '0;
    end
  end

endmodule

// File: tb/tb_ob_tbl_sched.sv
// Bench for ob_tbl_sched: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based table model.

module tb_ob_tbl_sched;
  import ob_pkg::*;

  localparam int N       = 16;
  localparam int AGE_MAX = 8;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   pop_vld, pop_rdy, push_vld, push_rdy, ins_vld, ins_rdy;
  logic   cnl_vld, cnl_rdy, cnl_rsp_vld, cnl_rsp_rdy, cnl_rsp_hit;
  logic   flush, flush_done;
  logic   tbl_head_pop, tbl_head_push, tbl_insert, tbl_cancel;
  logic   tbl_cancel_hit = 1'b0;
  table_t push_tbl, ins_tbl, cnl_rsp_tbl, tbl_push_tbl, tbl_insert_tbl;
  table_t tbl_cancel_hit_tbl = '0;
  uid_t   cnl_uid, tbl_cancel_uid;
  logic [$clog2(N+1)-1:0] occ_r;

  ob_tbl_sched #(.N(N), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pop_vld(pop_vld), .pop_rdy(pop_rdy),
    .push_vld(push_vld), .push_rdy(push_rdy), .push_tbl(push_tbl),
    .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_tbl(ins_tbl),
    .cnl_vld(cnl_vld), .cnl_rdy(cnl_rdy), .cnl_uid(cnl_uid),
    .cnl_rsp_vld(cnl_rsp_vld), .cnl_rsp_rdy(cnl_rsp_rdy),
    .cnl_rsp_hit(cnl_rsp_hit), .cnl_rsp_tbl(cnl_rsp_tbl),
    .flush(flush), .flush_done(flush_done),
    .tbl_head_pop(tbl_head_pop), .tbl_head_push(tbl_head_push),
    .tbl_insert(tbl_insert), .tbl_cancel(tbl_cancel),
    .tbl_push_tbl(tbl_push_tbl), .tbl_insert_tbl(tbl_insert_tbl),
    .tbl_cancel_uid(tbl_cancel_uid),
    .tbl_cancel_hit(tbl_cancel_hit), .tbl_cancel_hit_tbl(tbl_cancel_hit_tbl),
    .occ_r(occ_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference table contents (front = head), response and flush bookkeeping.
  table_t mq[$];
  int     m_age = 0;
  bit     m_rsp = 0;
  bit     m_flush = 0;
  bit     m_rsp_hit = 0;
  table_t m_rsp_tbl = '0;
  int     gen = 0;
  uid_t   nxt_uid = 8'd1;

  function automatic int find_uid(input uid_t u);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i][7:0] == u) return i;
    return -1;
  endfunction

  function automatic table_t mk();
    table_t t;
    t = $urandom();
    t[7:0] = nxt_uid;
    nxt_uid++;
    return t;
  endfunction

  // The table answers cancel lookups from its current contents; mq holds the
  // current contents from just after each rising edge until the falling edge.
  always begin
    @(posedge clk);
    #1;
    gen++;
  end

  always @(cnl_uid or gen) begin : lookup
    int k;
    k = find_uid(cnl_uid);
    tbl_cancel_hit     = (k >= 0);
    tbl_cancel_hit_tbl = (k >= 0) ? mq[k] : '0;
  end

  task automatic model_cycle();
    int sz, win, k;
    bit allow, aged, taken, fl_pop, fl_done;
    int order[4];
    bit el[4];
    bit vl[4];
    bit er[4];
    sz    = mq.size();
    allow = !m_flush && (m_rsp || !flush);
    el    = '{allow && sz > 0, allow && !m_rsp, allow && sz < N, allow && sz < N};
    vl    = '{pop_vld, cnl_vld, push_vld, ins_vld};
    aged  = (m_age == AGE_MAX);
    if (aged) order = '{0, 1, 3, 2};
    else      order = '{0, 1, 2, 3};
    win   = -1;
    taken = 0;
    for (int p = 0; p < 4; p++) begin
      er[order[p]] = el[order[p]] && !taken;
      if (vl[order[p]] && el[order[p]] && !taken) begin
        win   = order[p];
        taken = 1;
      end
    end
    fl_pop  = m_flush && sz > 0;
    fl_done = m_flush && sz == 0;

    chk("rdy", 64'({pop_rdy, cnl_rdy, push_rdy, ins_rdy}), 64'({er[0], er[1], er[2], er[3]}));
    chk("strobe", 64'({tbl_head_pop, tbl_cancel, tbl_head_push, tbl_insert}),
        64'({(win == 0) || fl_pop, win == 1, win == 2, win == 3}));
    chk("occ", 64'(occ_r), 64'(sz));
    chk("flush_done", 64'(flush_done), 64'(fl_done));
    chk("rsp", 64'({cnl_rsp_vld, cnl_rsp_hit, cnl_rsp_tbl}), 64'({m_rsp, m_rsp_hit, m_rsp_tbl}));
    if (win == 1) chk("cnl_uid", 64'(tbl_cancel_uid), 64'(cnl_uid));
    if (win == 2) chk("push_tbl", 64'(tbl_push_tbl), 64'(push_tbl));
    if (win == 3) chk("ins_tbl", 64'(tbl_insert_tbl), 64'(ins_tbl));

    k = find_uid(cnl_uid);
    case (win)
      0: void'(mq.pop_front());
      1: begin
        m_rsp_hit = (k >= 0);
        m_rsp_tbl = (k >= 0) ? mq[k] : '0;
        if (k >= 0) mq.delete(k);
      end
      2: mq.push_front(push_tbl);
      3: mq.push_back(ins_tbl);
      default: ;
    endcase
    if (fl_pop) void'(mq.pop_front());

    if (fl_done || win == 3 || !ins_vld) m_age = 0;
    else if (m_age < AGE_MAX)            m_age++;

    if (m_flush) begin
      if (fl_done) m_flush = 0;
    end else if (m_rsp) begin
      if (cnl_rsp_rdy) begin
        m_rsp     = 0;
        m_rsp_hit = 0;
        m_rsp_tbl = '0;
        m_flush   = flush;
      end
    end else if (flush) begin
      m_flush = 1;
    end else if (win == 1) begin
      m_rsp = 1;
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_occ", 64'(occ_r), 64'(0));
      chk("rst_rdy", 64'({pop_rdy, push_rdy, ins_rdy, cnl_rdy}), 64'(0));
      chk("rst_strobe", 64'({tbl_head_pop, tbl_head_push, tbl_insert, tbl_cancel}), 64'(0));
      chk("rst_rsp", 64'({cnl_rsp_vld, cnl_rsp_hit, cnl_rsp_tbl}), 64'(0));
      chk("rst_done", 64'(flush_done), 64'(0));
      mq.delete();
      m_age     = 0;
      m_rsp     = 0;
      m_flush   = 0;
      m_rsp_hit = 0;
      m_rsp_tbl = '0;
    end else begin
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(output int pops, output bit done);
    flush = 1'b1;
    step();
    flush = 1'b0;
    pops  = 0;
    done  = 0;
    for (int i = 0; i < 60; i++) begin
      if (flush_done) begin
        done = 1;
        break;
      end
      if (tbl_head_pop) pops++;
      step();
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g, p, idx, o, seq, nstb, seen;
    bit d;
    table_t last, ent;
    bit gp, gc, gu, gi;

    rst_n = 1'b0;
    {pop_vld, push_vld, ins_vld, cnl_vld, cnl_rsp_rdy, flush} = '0;
    push_tbl = '0;
    ins_tbl  = '0;
    cnl_uid  = '0;
    repeat (3) step();
    chk("L_rst_occ", 64'(occ_r), 64'(0));
    chk("L_rst_push_rdy", 64'(push_rdy), 64'(0));
    rst_n       = 1'b1;
    cnl_rsp_rdy = 1'b1;

    // Fill the table with held insert requests.
    ins_vld = 1'b1;
    g = 0;
    for (int i = 0; i < 20; i++) begin
      ins_tbl = mk();
      #1;
      if (ins_rdy) g++;
      step();
    end
    chk("L_fill_grants", 64'(g), 64'(16));
    chk("L_fill_occ", 64'(occ_r), 64'(16));
    chk("L_fill_ins_rdy", 64'(ins_rdy), 64'(0));
    pop_vld = 1'b1;
    #1;
    chk("L_full_pop_rdy", 64'({pop_rdy, ins_rdy}), 64'(2));
    step();
    pop_vld = 1'b0;
    #1;
    chk("L_refill_rdy", 64'(ins_rdy), 64'(1));
    step();
    ins_vld = 1'b0;

    do_flush(p, d);
    chk("L_flush16_pops", 64'(p), 64'(16));
    chk("L_flush16_done", 64'(d), 64'(1));
    step();

    // Three entries, then all four requesters at once.
    ins_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins_tbl = mk();
      last    = ins_tbl;
      step();
    end
    ins_vld = 1'b0;
    #1;
    chk("L_occ3", 64'(occ_r), 64'(3));
    {pop_vld, cnl_vld, push_vld, ins_vld} = 4'hf;
    cnl_uid  = last[7:0];
    push_tbl = mk();
    ins_tbl  = mk();
    seq = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nstb = int'(tbl_head_pop) + int'(tbl_cancel) + int'(tbl_head_push) + int'(tbl_insert);
      chk("L_one_strobe", 64'(nstb), 64'(1));
      seq = seq * 16 + (tbl_head_pop ? 1 : tbl_cancel ? 2 : tbl_head_push ? 3 : tbl_insert ? 4 : 0);
      {gp, gc, gu, gi} = {tbl_head_pop, tbl_cancel, tbl_head_push, tbl_insert};
      step();
      if (gp) pop_vld = 1'b0;
      if (gc) cnl_vld = 1'b0;
      if (gu) push_vld = 1'b0;
      if (gi) ins_vld = 1'b0;
    end
    chk("L_grant_order", 64'(seq), 64'('h1234));
    chk("L_occ_after_mix", 64'(occ_r), 64'(3));

    // Push held continuously; insert must break through after aging.
    push_vld = 1'b1;
    ins_vld  = 1'b1;
    idx = 0;
    ent = '0;
    for (int i = 0; i < 12; i++) begin
      push_tbl = mk();
      ins_tbl  = mk();
      #1;
      if (tbl_insert) begin
        idx = i + 1;
        ent = ins_tbl;
        break;
      end
      step();
    end
    chk("L_age_win_cycle", 64'(idx), 64'(9));
    step();
    push_tbl = mk();
    ins_tbl  = mk();
    #1;
    chk("L_age_cleared", 64'({tbl_head_push, tbl_insert}), 64'(2));
    step();
    push_vld = 1'b0;
    ins_vld  = 1'b0;

    // Cancel hit with the response held off.
    cnl_uid     = ent[7:0];
    cnl_vld     = 1'b1;
    cnl_rsp_rdy = 1'b0;
    o = int'(occ_r);
    #1;
    chk("L_cnl_rdy", 64'(cnl_rdy), 64'(1));
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("L_hold_rsp", 64'({cnl_rsp_vld, cnl_rsp_hit, cnl_rdy}), 64'(6));
      chk("L_hold_tbl", 64'(cnl_rsp_tbl), 64'(ent));
      chk("L_hold_occ", 64'(occ_r), 64'(o - 1));
      step();
    end
    cnl_rsp_rdy = 1'b1;
    cnl_vld     = 1'b0;
    step();
    #1;
    chk("L_rsp_released", 64'(cnl_rsp_vld), 64'(0));

    // Cancel on an empty table.
    do_flush(p, d);
    chk("L_flush_done2", 64'(d), 64'(1));
    step();
    cnl_uid = 8'h00;
    cnl_vld = 1'b1;
    step();
    cnl_vld = 1'b0;
    #1;
    chk("L_miss_rsp", 64'({cnl_rsp_vld, cnl_rsp_hit}), 64'(2));
    chk("L_miss_tbl", 64'(cnl_rsp_tbl), 64'(0));
    chk("L_miss_occ", 64'(occ_r), 64'(0));
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      pop_vld  = ($urandom_range(0, 3) < 2);
      push_vld = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) ins_vld = ~ins_vld;
      cnl_vld     = ($urandom_range(0, 4) == 0);
      cnl_rsp_rdy = ($urandom_range(0, 1) == 0);
      flush       = ($urandom_range(0, 120) == 0);
      push_tbl    = mk();
      ins_tbl     = mk();
      if (mq.size() > 0 && $urandom_range(0, 1) == 0)
        cnl_uid = mq[$urandom_range(0, mq.size() - 1)][7:0];
      else
        cnl_uid = uid_t'($urandom());
      step();
    end
    {pop_vld, push_vld, ins_vld, cnl_vld, flush} = '0;
    cnl_rsp_rdy = 1'b1;
    repeat (2) step();
    do_flush(p, d);
    chk("L_rand_drain", 64'(d), 64'(1));
    step();

    // Flush five entries, then a reset in the middle of a flush.
    ins_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ins_tbl = mk();
      step();
    end
    ins_vld = 1'b0;
    #1;
    chk("L_occ5", 64'(occ_r), 64'(5));
    do_flush(p, d);
    chk("L_flush5_pops", 64'(p), 64'(5));
    chk("L_flush5_done", 64'(d), 64'(1));
    chk("L_flush5_occ", 64'(occ_r), 64'(0));
    step();
    ins_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ins_tbl = mk();
      step();
    end
    ins_vld = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    seen  = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (flush_done) seen = 1;
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (flush_done) seen = 1;
      step();
    end
    chk("L_rst_flush_nodone", 64'(seen), 64'(0));
    chk("L_rst_flush_occ", 64'(occ_r), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
